// File: rtl/yolo_upsamp_pkg.sv
// Shared types and helpers for the 2x nearest-neighbour stream upsampler.
package yolo_upsamp_pkg;

  localparam int unsigned DefaultDataW = 32;

  typedef enum logic [2:0] {
    StIdle,
    StPass0,
    StPass1,
    StDrain,
    StDone
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((64'd1 << res) < 64'(value)) res++;
    return res;
  endfunction

endpackage

// File: rtl/yolo_upsamp_linebuf.sv
// One-row pixel buffer: synchronous write, asynchronous read so it maps onto LUTRAM.
module yolo_upsamp_linebuf
  import yolo_upsamp_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = (clog2(DEPTH) > 0) ? clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/yolo_upsamp_x2_stream.sv
// 2x nearest-neighbour upsampler between two FIFOs: each input pixel becomes a 2x2
// output block in raster order; the second output row of each pair replays the line buffer.
module yolo_upsamp_x2_stream
  import yolo_upsamp_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned MAX_W  = 32,
  parameter int unsigned DIM_W  = 6
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic [DIM_W-1:0]  cfg_width,
  input  logic [DIM_W-1:0]  cfg_height,
  input  logic [DATA_W-1:0] in_dout,
  input  logic              in_empty_n,
  output logic              in_read,
  output logic [DATA_W-1:0] out_din,
  input  logic              out_full_n,
  output logic              out_write
);

  localparam int unsigned      AW     = (clog2(MAX_W) > 0) ? clog2(MAX_W) : 1;
  localparam logic [DIM_W-1:0] DimOne = DIM_W'(1);

  state_e            state_q, state_d;
  logic [DIM_W-1:0]  col_q, col_d, row_q, row_d, w_q, w_d, h_q, h_d;
  logic              dup_q, dup_d, out_vld_q, out_vld_d;
  logic [DATA_W-1:0] out_din_q, out_din_d;

  logic              slot_free, col_last, row_last, load, lb_we;
  logic [DIM_W-1:0]  col_inc;
  logic [DATA_W-1:0] load_data, lb_rdata;

  assign slot_free = ~out_vld_q | out_full_n;
  assign col_last  = (col_q == w_q - DimOne);
  assign row_last  = (row_q == h_q - DimOne);
  assign col_inc   = col_last ? '0 : col_q + DimOne;

  yolo_upsamp_linebuf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_W),
    .AW     (AW)
  ) u_linebuf (
    .clk   (ap_clk),
    .we    (lb_we),
    .waddr (col_q[AW-1:0]),
    .wdata (in_dout),
    .raddr (col_q[AW-1:0]),
    .rdata (lb_rdata)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    dup_d     = dup_q;
    w_d       = w_q;
    h_d       = h_q;
    in_read   = 1'b0;
    lb_we     = 1'b0;
    load      = 1'b0;
    load_data = lb_rdata;

    case (state_q)
      StIdle: begin
        if (ap_start) begin
          w_d     = cfg_width;
          h_d     = cfg_height;
          col_d   = '0;
          row_d   = '0;
          dup_d   = 1'b0;
          state_d = (cfg_width != '0 && cfg_height != '0) ? StPass0 : StDone;
        end
      end
      StPass0: begin
        if (!dup_q) begin
          in_read = in_empty_n & slot_free;
          if (in_read) begin
            load      = 1'b1;
            load_data = in_dout;
            lb_we     = 1'b1;
            dup_d     = 1'b1;
          end
        end else if (slot_free) begin
          // Second horizontal copy comes back out of the line buffer.
          load  = 1'b1;
          dup_d = 1'b0;
          col_d = col_inc;
          if (col_last) state_d = StPass1;
        end
      end
      StPass1: begin
        if (slot_free) begin
          load  = 1'b1;
          dup_d = ~dup_q;
          if (dup_q) begin
            col_d = col_inc;
            if (col_last) begin
              if (row_last) begin
                state_d = StDrain;
              end else begin
                row_d   = row_q + DimOne;
                state_d = StPass0;
              end
            end
          end
        end
      end
      StDrain: begin
        if (!out_vld_q || out_full_n) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    out_vld_d = out_vld_q;
    out_din_d = out_din_q;
    if (load) begin
      out_vld_d = 1'b1;
      out_din_d = load_data;
    end else if (out_full_n) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= StIdle;
      col_q     <= '0;
      row_q     <= '0;
      dup_q     <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      out_vld_q <= 1'b0;
      out_din_q <= '0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      row_q     <= row_d;
      dup_q     <= dup_d;
      w_q       <= w_d;
      h_q       <= h_d;
      out_vld_q <= out_vld_d;
      out_din_q <= out_din_d;
    end
  end

  assign out_write = out_vld_q & out_full_n;
  assign out_din   = out_din_q;
  assign ap_done   = (state_q == StDone);
  assign ap_ready  = ap_done;
  assign ap_idle   = (state_q == StIdle);

endmodule
